ras_ctrl: RTL and testbench

Return-address-stack controller between the IF pre-decode and the RAS. It classifies each instruction leaving IF as a call (push), return (pop) or neither using the RISC-V link-register hint rules. It tracks speculative RAS operations through the ID and EX stages and, on a pipeline flush, emits the rollback strobes that undo squashed operations. It also keeps a saturating occupancy count so that a return never pops an empty stack.

---
 rtl/ras_ctrl.sv | 121 ++++++++++++
 tb/tb_ras_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: classifies IF instructions as call/return,
// tracks speculative RAS ops through ID/EX and rolls them back on flush.
module ras_ctrl #(
  parameter int STACK_ADDR_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 if_instr,
  input  logic                        if_valid,
  input  logic                        stall,
  input  logic                        flush_id,
  input  logic                        flush_ex,
  output logic                        push,
  output logic                        pop,
  output logic                        rollback_pop_id,
  output logic                        rollback_push_id,
  output logic                        rollback_push_ex,
  output logic                        ras_valid,
  output logic [STACK_ADDR_WIDTH:0]   occupancy
);

  localparam int OW = STACK_ADDR_WIDTH + 2;
  localparam logic [OW-1:0] DEPTH_X = OW'(1) << STACK_ADDR_WIDTH;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [2:0] funct3;
  logic       link_rd;
  logic       link_rs1;
  logic       is_jal;
  logic       is_jalr;
  logic       is_call;
  logic       is_ret;
  logic       advance;
  logic       unused_instr_bits;

  logic id_push_q, id_push_d;
  logic id_pop_q, id_pop_d;
  logic ex_push_q, ex_push_d;
  logic [STACK_ADDR_WIDTH:0] occ_q, occ_d;
  logic [OW-1:0] occ_sum;

  assign opcode   = if_instr[6:0];
  assign rd       = if_instr[11:7];
  assign funct3   = if_instr[14:12];
  assign rs1      = if_instr[19:15];
  assign unused_instr_bits = ^if_instr[31:20];

  assign link_rd  = (rd == 5'd1) || (rd == 5'd5);
  assign link_rs1 = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign is_jal   = (opcode == 7'b1101111);
  assign is_jalr  = (opcode == 7'b1100111) && (funct3 == 3'b000);

  // Both-linked JALR with rs1 != rd is treated as a plain call (no coroutine swap).
  assign is_call  = (is_jal && link_rd) || (is_jalr && link_rd);
  assign is_ret   = is_jalr && !link_rd && link_rs1;

  always_comb begin
    advance          = rst_n && if_valid && !stall && !flush_id && !flush_ex;
    push             = advance && is_call;
    pop              = advance && is_ret && (occ_q != '0);
    rollback_pop_id  = 1'b0;
    rollback_push_id = 1'b0;
    rollback_push_ex = 1'b0;
    if (rst_n && flush_ex) begin
      rollback_pop_id  = id_pop_q;
      rollback_push_id = id_push_q;
      rollback_push_ex = ex_push_q;
    end else if (rst_n && flush_id) begin
      rollback_pop_id  = id_pop_q;
      rollback_push_id = id_push_q;
    end
  end

  always_comb begin
    id_push_d = push;
    id_pop_d  = pop;
    ex_push_d = id_push_q;
    if (flush_ex || flush_id) begin
      id_push_d = 1'b0;
      id_pop_d  = 1'b0;
      ex_push_d = 1'b0;
    end else if (stall) begin
      id_push_d = id_push_q;
      id_pop_d  = id_pop_q;
      ex_push_d = 1'b0;
    end
  end

  // Net change lies in [-3, +2]; MSB of the widened sum flags underflow.
  always_comb begin
    occ_sum = {1'b0, occ_q} + OW'(push) + OW'(rollback_pop_id)
              - OW'(pop) - OW'(rollback_push_id) - OW'(rollback_push_ex);
    if (occ_sum[OW-1]) begin
      occ_d = '0;
    end else if (occ_sum > DEPTH_X) begin
      occ_d = DEPTH_X[STACK_ADDR_WIDTH:0];
    end else begin
      occ_d = occ_sum[STACK_ADDR_WIDTH:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_push_q <= 1'b0;
      id_pop_q  <= 1'b0;
      ex_push_q <= 1'b0;
      occ_q     <= '0;
    end else begin
      id_push_q <= id_push_d;
      id_pop_q  <= id_pop_d;
      ex_push_q <= ex_push_d;
      occ_q     <= occ_d;
    end
  end

  assign occupancy = occ_q;
  assign ras_valid = (occ_q != '0);

endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl: a behavioural model queues the expected
// outputs for each driven cycle; they are popped and compared mid-cycle.
module tb_ras_ctrl;

  localparam int W     = 4;
  localparam int DEPTH = 1 << W;

  localparam logic [31:0] JAL_X1      = 32'h008000EF;
  localparam logic [31:0] JAL_X5      = 32'h008002EF;
  localparam logic [31:0] JAL_X0      = 32'h0080006F;
  localparam logic [31:0] RET_X1      = 32'h00008067;
  localparam logic [31:0] RET_X5      = 32'h00028067;
  localparam logic [31:0] JALR_X1_X1  = 32'h000080E7;
  localparam logic [31:0] JALR_X1_X5  = 32'h000280E7;
  localparam logic [31:0] JALR_X5_X1  = 32'h000082E7;
  localparam logic [31:0] JALR_F3     = 32'h00009067;
  localparam logic [31:0] NOP         = 32'h00000013;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  if_instr;
  logic         if_valid, stall, flush_id, flush_ex;
  logic         push, pop, rollback_pop_id, rollback_push_id, rollback_push_ex, ras_valid;
  logic [W:0]   occupancy;

  typedef struct packed {
    logic [5:0] flags;
    logic [W:0] occ;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   push_seen;

  int m_occ;
  bit m_id_push, m_id_pop, m_ex_push;

  logic [31:0] instr_tab [10];

  ras_ctrl #(.STACK_ADDR_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_valid(if_valid),
    .stall(stall), .flush_id(flush_id), .flush_ex(flush_ex),
    .push(push), .pop(pop), .rollback_pop_id(rollback_pop_id),
    .rollback_push_id(rollback_push_id), .rollback_push_ex(rollback_push_ex),
    .ras_valid(ras_valid), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void classify(input logic [31:0] i, output bit c, output bit r);
    bit lrd, lrs;
    lrd = (i[11:7] == 5'd1) || (i[11:7] == 5'd5);
    lrs = (i[19:15] == 5'd1) || (i[19:15] == 5'd5);
    c = 0;
    r = 0;
    if (i[6:0] == 7'b1101111) begin
      c = lrd;
    end else if (i[6:0] == 7'b1100111 && i[14:12] == 3'b000) begin
      if (lrd && (!lrs || i[19:15] == i[11:7])) c = 1;
      else if (!lrd && lrs) r = 1;
      else if (lrd && lrs) c = 1;
    end
  endfunction

  // Drive one cycle: model predicts, DUT is sampled at negedge, model steps at posedge.
  task automatic cycle(input logic [31:0] instr, input bit v, input bit st, input bit fi, input bit fe);
    bit c, r, adv, e_push, e_pop, rb_pop, rb_pid, rb_pex;
    int nxt;
    exp_t e, got;
    if_instr = instr; if_valid = v; stall = st; flush_id = fi; flush_ex = fe;
    classify(instr, c, r);
    adv    = rst_n && v && !st && !fi && !fe;
    e_push = adv && c;
    e_pop  = adv && r && (m_occ != 0);
    rb_pop = rst_n && (fe || fi) && m_id_pop;
    rb_pid = rst_n && (fe || fi) && m_id_push;
    rb_pex = rst_n && fe && m_ex_push;
    e.flags = {e_push, e_pop, rb_pop, rb_pid, rb_pex, (m_occ != 0)};
    e.occ   = (W+1)'(m_occ);
    sb.push_back(e);

    @(negedge clk);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      got.flags = {push, pop, rollback_pop_id, rollback_push_id, rollback_push_ex, ras_valid};
      got.occ   = occupancy;
      e = sb.pop_front();
      check("flags", 32'(got.flags), 32'(e.flags));
      check("occupancy", 32'(got.occ), 32'(e.occ));
      if (push === 1'b1) push_seen++;
    end

    @(posedge clk);
    if (!rst_n) begin
      m_occ = 0; m_id_push = 0; m_id_pop = 0; m_ex_push = 0;
    end else begin
      nxt = m_occ + int'(e_push) - int'(e_pop) + int'(rb_pop) - int'(rb_pid) - int'(rb_pex);
      m_occ = (nxt < 0) ? 0 : (nxt > DEPTH) ? DEPTH : nxt;
      if (fe || fi) begin
        m_id_push = 0; m_id_pop = 0; m_ex_push = 0;
      end else if (st) begin
        m_ex_push = 0;
      end else begin
        m_ex_push = m_id_push;
        m_id_push = e_push;
        m_id_pop  = e_pop;
      end
    end
    #1;
  endtask

  task automatic flush_all();
    cycle(NOP, 0, 0, 0, 1);
  endtask

  initial begin
    instr_tab[0] = JAL_X1;     instr_tab[1] = JAL_X5;     instr_tab[2] = JAL_X0;
    instr_tab[3] = RET_X1;     instr_tab[4] = RET_X5;     instr_tab[5] = JALR_X1_X1;
    instr_tab[6] = JALR_X1_X5; instr_tab[7] = JALR_X5_X1; instr_tab[8] = JALR_F3;
    instr_tab[9] = NOP;
    m_occ = 0; m_id_push = 0; m_id_pop = 0; m_ex_push = 0;
    rst_n = 0; if_instr = NOP; if_valid = 0; stall = 0; flush_id = 0; flush_ex = 0;
    @(posedge clk); #1;
    cycle(JAL_X1, 1, 0, 0, 0);               // held in reset: everything 0
    rst_n = 1;
    check("reset_occ", 32'(occupancy), 0);

    // Return on empty stack is a no-op.
    cycle(RET_X1, 1, 0, 0, 0);
    check("empty_ret_occ", 32'(occupancy), 0);

    // Call travels IF -> ID -> EX.
    cycle(JAL_X1, 1, 0, 0, 0);
    check("call_occ", 32'(occupancy), 1);
    cycle(NOP, 1, 0, 0, 0);
    cycle(NOP, 1, 0, 0, 0);
    cycle(RET_X1, 1, 0, 0, 0);
    check("ret_occ", 32'(occupancy), 0);
    cycle(NOP, 1, 0, 0, 0);

    // Call in ID squashed by flush_id.
    cycle(JAL_X1, 1, 0, 0, 0);
    cycle(NOP, 1, 0, 1, 0);
    check("flush_id_occ", 32'(occupancy), 0);
    cycle(NOP, 1, 0, 0, 1);                  // ex_push must already be clear

    // Base depth 1, then call in EX + return in ID squashed by flush_ex (net 0).
    cycle(JAL_X1, 1, 0, 0, 0);
    cycle(NOP, 1, 0, 0, 0);
    cycle(NOP, 1, 0, 0, 0);
    cycle(JAL_X1, 1, 0, 0, 0);
    cycle(RET_X1, 1, 0, 0, 0);
    cycle(NOP, 1, 0, 0, 1);
    check("flush_ex_net0_occ", 32'(occupancy), 1);
    cycle(NOP, 1, 0, 0, 1);

    // Two calls in ID and EX squashed together (net -2).
    cycle(JAL_X5, 1, 0, 0, 0);
    cycle(JALR_X1_X5, 1, 0, 0, 0);
    cycle(NOP, 1, 0, 0, 1);
    check("flush_ex_net2_occ", 32'(occupancy), 1);

    // Call stalled in IF for 3 cycles, then released: one push.
    push_seen = 0;
    cycle(JAL_X1, 1, 1, 0, 0);
    cycle(JAL_X1, 1, 1, 0, 0);
    cycle(JAL_X1, 1, 1, 0, 0);
    cycle(JAL_X1, 1, 0, 0, 0);
    check("stall_push_count", 32'(push_seen), 1);
    cycle(NOP, 1, 1, 0, 0);                  // call held in ID, EX gets bubble
    cycle(NOP, 1, 1, 1, 0);                  // flush_id overlapping stall
    check("stall_flush_occ", 32'(occupancy), 1);

    // Pseudo-random mix of instructions, stalls and flushes.
    for (int k = 0; k < 60; k++) begin
      cycle(instr_tab[$urandom_range(0, 9)], ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 11) == 0));
    end
    flush_all();

    // Saturation, then reset mid-stream.
    for (int k = 0; k < 18; k++) cycle(JAL_X1, 1, 0, 0, 0);
    check("saturate_occ", 32'(occupancy), DEPTH);
    rst_n = 0;
    cycle(JAL_X1, 1, 0, 0, 1);
    rst_n = 1;
    check("post_reset_occ", 32'(occupancy), 0);
    cycle(NOP, 1, 0, 0, 1);                  // nothing left to roll back
    cycle(NOP, 1, 0, 0, 0);

    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
